// File: rtl/song_reader_pkg.sv
// song_reader shared types: widths, FSM states and the ROM word layout.
// Imported by the interface, the ROM and the reader itself.
package song_reader_pkg;

  localparam int SONG_W = 2;
  localparam int IDX_W  = 5;
  localparam int NOTE_W = 6;
  localparam int DUR_W  = 6;
  localparam int ADDR_W = SONG_W + IDX_W;

  localparam logic [DUR_W-1:0] END_MARKER = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_ROM,
    S_WAIT_NOTE,
    S_NEXT,
    S_END
  } state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_word_t;

endpackage

// File: rtl/song_reader_if.sv
// Control-unit / note-player signals seen by the song reader.
// master drives play/song/note_done; slave is the reader.
interface song_reader_if;
  import song_reader_pkg::*;

  logic              play;
  logic              reset_player;
  logic [SONG_W-1:0] song;
  logic              note_done;
  logic              new_note;
  logic [NOTE_W-1:0] note;
  logic [DUR_W-1:0]  duration;
  logic              song_done;

  modport master (
    output play, reset_player, song, note_done,
    input  new_note, note, duration, song_done
  );

  modport slave (
    input  play, reset_player, song, note_done,
    output new_note, note, duration, song_done
  );

endinterface

// File: rtl/song_rom.sv
// Note ROM: four songs of 32 {note, duration} slots.
// Address is registered, so data follows addr by one cycle.
module song_rom
  import song_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr,
  output rom_word_t         data
);

  logic [ADDR_W-1:0] addr_q;
  logic [SONG_W-1:0] s;
  logic [IDX_W-1:0]  i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) addr_q <= '0;
    else          addr_q <= addr;
  end

  assign {s, i} = addr_q;

  // Song 0 and 1 run all 32 slots; song 2 ends at slot 3, song 3 at 16.
  always_comb begin
    data = '0;
    unique case (s)
      2'd0: begin
        data.note = NOTE_W'(i) * 6'd3 + 6'd1;
        data.dur  = DUR_W'(i % 5'd7) + 6'd1;
      end
      2'd1: begin
        if (i == 5'd0) begin
          data.note = 6'd20;
          data.dur  = 6'd8;
        end else if (i == 5'd2) begin
          data.note = 6'd0;
          data.dur  = 6'd4;
        end else begin
          data.note = NOTE_W'(i) + 6'd20;
          data.dur  = DUR_W'(i % 5'd5) + 6'd1;
        end
      end
      2'd2: begin
        if (i < 5'd3) begin
          data.note = NOTE_W'(i) + 6'd10;
          data.dur  = DUR_W'(i) + 6'd3;
        end else if (i == 5'd3) begin
          data.note = NOTE_W'(i);
          data.dur  = END_MARKER;
        end else begin
          data.note = NOTE_W'(i);
          data.dur  = 6'd1;
        end
      end
      2'd3: begin
        if (i < 5'd16) begin
          data.note = NOTE_W'(i) + 6'd40;
          data.dur  = 6'd2;
        end
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/song_reader.sv
// Walks the note ROM for the selected song and issues one note
// per new_note/note_done handshake, then pulses song_done.
module song_reader
  import song_reader_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  song_reader_if.slave bus
);

  state_t            state, state_n;
  logic [IDX_W-1:0]  index, index_n;
  logic [SONG_W-1:0] song_q, song_n;
  logic              new_q, new_n;
  logic              done_q, done_n;
  logic [NOTE_W-1:0] note_q, note_n;
  logic [DUR_W-1:0]  dur_q, dur_n;
  logic [ADDR_W-1:0] addr;
  rom_word_t         rom;

  assign addr = {song_q, index};

  song_rom u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .data    (rom)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      index  <= '0;
      song_q <= '0;
      new_q  <= 1'b0;
      done_q <= 1'b0;
      note_q <= '0;
      dur_q  <= '0;
    end else begin
      state  <= state_n;
      index  <= index_n;
      song_q <= song_n;
      new_q  <= new_n;
      done_q <= done_n;
      note_q <= note_n;
      dur_q  <= dur_n;
    end
  end

  always_comb begin
    state_n = state;
    index_n = index;
    song_n  = song_q;
    new_n   = 1'b0;
    done_n  = 1'b0;
    note_n  = note_q;
    dur_n   = dur_q;
    if (bus.reset_player) begin
      state_n = S_IDLE;
      index_n = '0;
      note_n  = '0;
      dur_n   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.play) begin
            song_n  = bus.song;
            state_n = S_FETCH;
          end
        end
        S_FETCH: state_n = S_WAIT_ROM;
        // Paused here the ROM keeps re-reading the same slot.
        S_WAIT_ROM: begin
          if (rom.dur == END_MARKER) begin
            done_n  = 1'b1;
            state_n = S_END;
          end else if (bus.play) begin
            new_n   = 1'b1;
            note_n  = rom.note;
            dur_n   = rom.dur;
            state_n = S_WAIT_NOTE;
          end
        end
        S_WAIT_NOTE: begin
          if (bus.note_done) state_n = S_NEXT;
        end
        S_NEXT: begin
          if (index == '1) begin
            done_n  = 1'b1;
            state_n = S_END;
          end else begin
            index_n = index + 1'b1;
            state_n = S_FETCH;
          end
        end
        S_END: state_n = S_END;
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign bus.new_note  = new_q;
  assign bus.song_done = done_q;
  assign bus.note      = note_q;
  assign bus.duration  = dur_q;

endmodule
